// File: rtl/bridge_pkg.sv
// Shared definitions for the ASCII command bridge receiver.
// Holds the message framing constants, the receive FSM state type and a small
// terminator helper used by bridge_rx.
package bridge_pkg;

  localparam logic [7:0] PREAMBLE_READ  = 8'h52;  // 'R'
  localparam logic [7:0] PREAMBLE_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CR             = 8'h0D;
  localparam logic [7:0] LF             = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    EOL
  } rx_state_e;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CR) || (b == LF);
  endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex-digit decoder.
// Ports:
//   data    - input byte
//   is_hex  - 1 when data is 0-9, A-F or a-f
//   nibble  - decoded digit value, 0 when is_hex is 0
module ascii_hex_decode (
  input  logic [7:0] data,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (data >= 8'h30 && data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = data[3:0];
    end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so offset by 9 to land on 10.
      is_hex = 1'b1;
      nibble = data[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/bridge_rx.sv
// ASCII command receiver: parses "R<addr>\r" and "W<addr><data>\r" byte
// streams from a UART receiver into a decoded bus request.
// Optional feature macro: BRIDGE_RX_ERROR_EN adds error_o, a one-cycle pulse
// one cycle after any aborted message.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   data_i     - received byte, qualified by valid_i
//   valid_i    - one-cycle byte strobe, always consumed
//   addr_o     - decoded address, held until the next request
//   data_o     - decoded write data (zero for reads)
//   rw_o       - 1 = write, 0 = read
//   valid_o    - one-cycle pulse when addr_o/data_o/rw_o carry a new request
//   error_o    - (BRIDGE_RX_ERROR_EN only) abort pulse
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o
`ifdef BRIDGE_RX_ERROR_EN
  ,
  output logic                  error_o
`endif
);

  localparam int unsigned AddrDigits = ADDR_WIDTH / 4;
  localparam int unsigned DataDigits = DATA_WIDTH / 4;
  localparam int unsigned MaxDigits  = (AddrDigits > DataDigits) ? AddrDigits : DataDigits;
  localparam int unsigned CntW       = $clog2(MaxDigits + 1);

  localparam logic [CntW-1:0] AddrLast = CntW'(AddrDigits - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DataDigits - 1);

  rx_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d;
  logic                  is_write_q, is_write_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  issue;

  logic       is_hex;
  logic [3:0] nibble;
  logic       is_pre;

  ascii_hex_decode u_hex (
    .data   (data_i),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  assign is_pre = (data_i == PREAMBLE_READ) || (data_i == PREAMBLE_WRITE);

  always_comb begin
    state_d    = state_q;
    addr_sr_d  = addr_sr_q;
    data_sr_d  = data_sr_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    if (valid_i) begin
      if (is_pre) begin
        // A preamble restarts parsing from any state; clear digits so an
        // abandoned message leaves nothing behind.
        state_d    = ADDR;
        is_write_d = (data_i == PREAMBLE_WRITE);
        addr_sr_d  = '0;
        data_sr_d  = '0;
        cnt_d      = '0;
      end else begin
        unique case (state_q)
          IDLE: ;  // stray bytes, including a trailing LF, are dropped
          ADDR: begin
            if (is_hex) begin
              addr_sr_d = (addr_sr_q << 4) | ADDR_WIDTH'(nibble);
              if (cnt_q == AddrLast) begin
                cnt_d   = '0;
                state_d = is_write_q ? DATA : EOL;
              end else begin
                cnt_d = cnt_q + CntW'(1);
              end
            end else begin
              state_d = IDLE;
            end
          end
          DATA: begin
            if (is_hex) begin
              data_sr_d = (data_sr_q << 4) | DATA_WIDTH'(nibble);
              if (cnt_q == DataLast) begin
                cnt_d   = '0;
                state_d = EOL;
              end else begin
                cnt_d = cnt_q + CntW'(1);
              end
            end else begin
              state_d = IDLE;
            end
          end
          EOL: begin
            state_d = IDLE;
            issue   = is_term(data_i);
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_sr_q  <= '0;
      data_sr_q  <= '0;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      valid_o    <= 1'b0;
      rw_o       <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
    end else begin
      state_q    <= state_d;
      addr_sr_q  <= addr_sr_d;
      data_sr_q  <= data_sr_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
      valid_o    <= issue;
      if (issue) begin
        addr_o <= addr_sr_q;
        data_o <= is_write_q ? data_sr_q : '0;
        rw_o   <= is_write_q;
      end
    end
  end

`ifdef BRIDGE_RX_ERROR_EN
  logic abort;

  always_comb begin
    abort = 1'b0;
    if (valid_i && state_q != IDLE) begin
      if (is_pre) begin
        abort = 1'b1;
      end else if (state_q == EOL) begin
        abort = !is_term(data_i);
      end else begin
        abort = !is_hex;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error_o <= 1'b0;
    end else begin
      error_o <= abort;
    end
  end
`endif

endmodule

// File: tb/tb_bridge_rx.sv
// Self-checking bench for bridge_rx: byte strings are driven one per cycle,
// expected requests are queued when their terminator is driven and compared
// when valid_o pulses.
module tb_bridge_rx;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] addr_o;
  logic [15:0] data_o;
  logic        rw_o;
  logic        valid_o;
`ifdef BRIDGE_RX_ERROR_EN
  logic        error_o;
`endif

  bridge_rx #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .addr_o  (addr_o),
    .data_o  (data_o),
    .rw_o    (rw_o),
    .valid_o (valid_o)
`ifdef BRIDGE_RX_ERROR_EN
    ,
    .error_o (error_o)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
    int          cyc;  // byte index while armed, expected pulse cycle once queued
  } exp_t;

  exp_t arm_q[$];
  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int pulse_cnt  = 0;
  int pulse_base = 0;
  int err_cnt    = 0;
  int err_base   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard side: every valid_o cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("addr", 32'(addr_o), 32'(mon_e.addr));
        check_eq("data", 32'(data_o), 32'(mon_e.data));
        check_eq("rw", 32'(rw_o), 32'(mon_e.rw));
        check_eq("latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

`ifdef BRIDGE_RX_ERROR_EN
  always @(negedge clk) begin
    if (!rst && error_o) err_cnt++;
  end
`endif

  // Arm an expected request completed by the byte at position idx of the next string.
  task automatic expect_at(input int idx, input logic [15:0] a, input logic [15:0] d,
                           input logic rw);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.rw   = rw;
    e.cyc  = idx;
    arm_q.push_back(e);
  endtask

  task automatic send_str(input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      data_i  = s[i];
      valid_i = 1'b1;
      if (arm_q.size() != 0 && arm_q[0].cyc == i) begin
        e     = arm_q.pop_front();
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  task automatic end_test(input string tag, input int pulses, input int errs);
    repeat (4) @(negedge clk);
    check_eq({tag, "_pulses"}, 32'(pulse_cnt - pulse_base), 32'(pulses));
    pulse_base = pulse_cnt;
`ifdef BRIDGE_RX_ERROR_EN
    check_eq({tag, "_errors"}, 32'(err_cnt - err_base), 32'(errs));
`endif
    err_base = err_cnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(valid_o), 32'd0);
    check_eq({tag, "_rw"}, 32'(rw_o), 32'd0);
    check_eq({tag, "_addr"}, 32'(addr_o), 32'd0);
    check_eq({tag, "_data"}, 32'(data_o), 32'd0);
`ifdef BRIDGE_RX_ERROR_EN
    check_eq({tag, "_error"}, 32'(error_o), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    data_i  = 8'h00;
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Read with CRLF: CR completes, LF ignored.
    expect_at(5, 16'h1A2F, 16'h0000, 1'b0);
    send_str("R1A2F\015\012");
    end_test("read_crlf", 1, 0);

    // Write with lowercase digits and LF terminator.
    expect_at(9, 16'hBEEF, 16'h0042, 1'b1);
    send_str("Wbeef0042\012");
    end_test("write_lf", 1, 0);

    // Bad digit aborts; following read is clean and has zero data.
    send_str("R12G4\015");
    end_test("bad_digit", 0, 1);
    expect_at(5, 16'h0001, 16'h0000, 1'b0);
    send_str("R0001\015");
    end_test("after_abort", 1, 0);

    // Preamble mid-message restarts as a write.
    expect_at(12, 16'h0003, 16'h0005, 1'b1);
    send_str("R12W00030005\015");
    end_test("restart", 1, 1);

    // Reset mid-write discards it and clears outputs.
    send_str("W1234");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    send_str("0000\015");  // would complete the write if state survived reset
    expect_at(5, 16'h00FF, 16'h0000, 1'b0);
    send_str("R00FF\015");
    end_test("post_reset", 1, 0);

    // Back-to-back reads; second preamble lands while valid_o is high.
    expect_at(5, 16'h1111, 16'h0000, 1'b0);
    expect_at(11, 16'h2222, 16'h0000, 1'b0);
    send_str("R1111\015R2222\015");
    end_test("back_to_back", 2, 0);

    check_eq("pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bridge_rx.md
BRIDGE_RX -- requirements
Module: bridge_rx

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: address width in bits; SHALL be a multiple of 4.
REQ-002 Parameter DATA_WIDTH, default 16: write-data width in bits; SHALL be a multiple of 4.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_i  input  8  received ASCII byte from the UART receiver.
REQ-006 valid_i  input  1  one-cycle strobe: data_i holds a new byte.
REQ-007 addr_o  output  ADDR_WIDTH  decoded request address.
REQ-008 data_o  output  DATA_WIDTH  decoded write data; zero for reads.
REQ-009 rw_o  output  1  1 = write, 0 = read.
REQ-010 valid_o  output  1  one-cycle pulse: addr_o/data_o/rw_o hold a complete request.

Function
REQ-011 Read message SHALL be 'R' (0x52), then ADDR_WIDTH/4 hex digits, then a terminator.
REQ-012 Write message SHALL be 'W' (0x57), then ADDR_WIDTH/4 address digits, DATA_WIDTH/4 data digits, then a terminator.
- Digits are most-significant first.
- Terminator is CR (0x0D) or LF (0x0A).
REQ-013 Hex digits SHALL be 0-9, A-F and a-f; preamble letters SHALL be uppercase only.
REQ-014 FSM states SHALL be IDLE, ADDR, DATA and EOL; transitions occur only on cycles with valid_i=1.
- IDLE: 'R' or 'W' -> ADDR; any other byte (including stray CR/LF) is ignored.
- ADDR: shift in a digit; the final address digit -> EOL (read) or DATA (write).
- DATA: shift in a digit; the final data digit -> EOL.
- EOL: CR or LF -> IDLE with the request issued.
REQ-015 A non-hex byte in ADDR/DATA, or a non-terminator byte in EOL, SHALL abort the message and return to IDLE with no valid_o.
REQ-016 Exception: an 'R' or 'W' received in ADDR, DATA or EOL SHALL abort the current message and start a new message of that type (next state ADDR).
REQ-017 valid_o SHALL rise the cycle after the terminator byte is sampled (latency 1) and SHALL last exactly one cycle.
REQ-018 addr_o, data_o and rw_o SHALL be updated in the same cycle valid_o rises and SHALL hold until the next valid_o.
REQ-019 A CRLF pair SHALL produce exactly one request: CR completes it, and LF is ignored in IDLE.
REQ-020 Digit shift registers SHALL be cleared on entry to ADDR, so an aborted message leaves no residue.
REQ-021 Back-to-back messages SHALL be accepted with zero idle cycles between bytes.
- A preamble arriving in the same cycle valid_o is high is accepted.
REQ-022 There is no backpressure; every byte with valid_i=1 SHALL be consumed in that cycle.

Reset
REQ-023 While rst=1 the FSM SHALL return to IDLE and the shift registers clear.
REQ-024 While rst=1: valid_o=0, rw_o=0, addr_o=0, data_o=0.
REQ-025 Reset SHALL take priority over valid_i; a message in progress is discarded silently.

Configuration
REQ-026 Macro BRIDGE_RX_ERROR_EN, when defined, SHALL add output port error_o (1 bit).
- error_o pulses one cycle, one cycle after any abort per REQ-015/REQ-016.
- error_o resets to 0.
REQ-027 Without BRIDGE_RX_ERROR_EN the port and its logic SHALL be absent; parsing behaviour is identical.

Structure
REQ-028 Package bridge_pkg SHALL hold:
- constants PREAMBLE_READ (0x52), PREAMBLE_WRITE (0x57), CR and LF;
- the rx state enum.
REQ-029 Combinational sub-module ascii_hex_decode SHALL map a byte to {is_hex, nibble[3:0]}.

Verification (defaults)
REQ-030 "R1A2F\r\n" -> one valid_o pulse; addr_o=0x1A2F, rw_o=0, data_o=0; the LF generates nothing.
REQ-031 "Wbeef0042\n" -> one pulse; addr_o=0xBEEF, data_o=0x0042, rw_o=1.
REQ-032 "R12G4\r" -> no valid_o; error_o pulses once (macro on); the following "R0001\r" -> addr_o=0x0001.
REQ-033 "R12W00030005\r" -> single pulse; addr_o=0x0003, data_o=0x0005, rw_o=1; error_o pulses once for the aborted read.
REQ-034 rst asserted after "W1234" -> no pulse, outputs 0; "R00FF\r" after reset -> addr_o=0x00FF.
REQ-035 Two back-to-back reads at one byte per cycle -> two pulses, addresses in order, none dropped.
